// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } mdState_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int DEFAULT_MULDIV_LATENCY = 4;
  localparam int DEFAULT_CNT_W = 4;

  // Saturating event counter step: never wraps past all-ones.
  function automatic logic [31:0] satInc(input logic [31:0] val, input logic en);
    if (en && (val != 32'hFFFF_FFFF)) begin
      satInc = val + 32'd1;
    end else begin
      satInc = val;
    end
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_muldiv_busy_tracker.sv
// HI/LO occupancy tracker: busy for MULDIV_LATENCY cycles after a mul/div leaves EX.
module muldiv_busy_tracker
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULDIV_LATENCY = DEFAULT_MULDIV_LATENCY,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic Clk,
  input  logic Rst,
  input  logic MulDivStartEx,
  output logic MulDivBusy
);

  localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(MULDIV_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  mdState_t         state;
  mdState_t         stateNext;
  logic [CNT_W-1:0] busyCnt;
  logic [CNT_W-1:0] busyCntNext;

  // State and down-counter registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= ST_IDLE;
      busyCnt <= CNT_ZERO;
    end else begin
      state   <= stateNext;
      busyCnt <= busyCntNext;
    end
  end

  // Next-state logic; a start while busy restarts the full latency window.
  always_comb begin
    stateNext   = state;
    busyCntNext = busyCnt;
    case (state)
      ST_IDLE: begin
        if (MulDivStartEx) begin
          stateNext   = ST_MD_BUSY;
          busyCntNext = LAT_CNT;
        end else begin
          stateNext   = ST_IDLE;
          busyCntNext = CNT_ZERO;
        end
      end
      ST_MD_BUSY: begin
        if (MulDivStartEx) begin
          stateNext   = ST_MD_BUSY;
          busyCntNext = LAT_CNT;
        end else if (busyCnt == CNT_ONE) begin
          stateNext   = ST_IDLE;
          busyCntNext = CNT_ZERO;
        end else begin
          stateNext   = ST_MD_BUSY;
          busyCntNext = busyCnt - CNT_ONE;
        end
      end
      default: begin
        stateNext   = ST_IDLE;
        busyCntNext = CNT_ZERO;
      end
    endcase
  end

  // Moore output.
  always_comb begin
    MulDivBusy = (state == ST_MD_BUSY);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller for PC, IF/ID and ID/EX (load-use, HI/LO occupancy, branch flush).
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULDIV_LATENCY = DEFAULT_MULDIV_LATENCY,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  RsId,
  input  logic [4:0]  RtId,
  input  logic        UsesRsId,
  input  logic        UsesRtId,
  input  logic        HiLoAccessId,
  input  logic        MemReadEx,
  input  logic [4:0]  DestEx,
  input  logic        MulDivStartEx,
  input  logic        BranchTakenEx,
  output logic        PCWriteEn,
  output logic        IFIDWriteEn,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        MulDivBusy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount,
  output logic [31:0] MdBusyCycles
`endif
);

  logic mdBusyRaw;
  logic loadUse;
  logic hiLoStall;
  logic stall;

  muldiv_busy_tracker #(
    .MULDIV_LATENCY (MULDIV_LATENCY),
    .CNT_W          (CNT_W)
  ) uBusyTracker (
    .Clk           (Clk),
    .Rst           (Rst),
    .MulDivStartEx (MulDivStartEx),
    .MulDivBusy    (mdBusyRaw)
  );

  // Hazard detection; writes to $zero never create a dependency.
  always_comb begin
    loadUse   = MemReadEx && (DestEx != REG_ZERO) &&
                ((UsesRsId && (RsId == DestEx)) || (UsesRtId && (RtId == DestEx)));
    hiLoStall = HiLoAccessId && (mdBusyRaw || MulDivStartEx);
    stall     = loadUse || hiLoStall;
  end

  // Pipeline-register controls: reset, then branch flush, then stall.
  always_comb begin
    PCWriteEn   = 1'b1;
    IFIDWriteEn = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXFlush   = 1'b0;
    MulDivBusy  = 1'b0;
    if (Rst) begin
      PCWriteEn   = 1'b1;
      IFIDWriteEn = 1'b1;
      IFIDFlush   = 1'b0;
      IDEXFlush   = 1'b0;
      MulDivBusy  = 1'b0;
    end else if (BranchTakenEx) begin
      // The stalled ID instruction is on the wrong path, so flushing wins.
      PCWriteEn   = 1'b1;
      IFIDWriteEn = 1'b1;
      IFIDFlush   = 1'b1;
      IDEXFlush   = 1'b1;
      MulDivBusy  = mdBusyRaw;
    end else if (stall) begin
      PCWriteEn   = 1'b0;
      IFIDWriteEn = 1'b0;
      IFIDFlush   = 1'b0;
      IDEXFlush   = 1'b1;
      MulDivBusy  = mdBusyRaw;
    end else begin
      PCWriteEn   = 1'b1;
      IFIDWriteEn = 1'b1;
      IFIDFlush   = 1'b0;
      IDEXFlush   = 1'b0;
      MulDivBusy  = mdBusyRaw;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      StallCycles  <= 32'd0;
      FlushCount   <= 32'd0;
      MdBusyCycles <= 32'd0;
    end else begin
      StallCycles  <= satInc(StallCycles, stall && !BranchTakenEx);
      FlushCount   <= satInc(FlushCount, BranchTakenEx);
      MdBusyCycles <= satInc(MdBusyCycles, mdBusyRaw);
    end
  end
`endif

endmodule
